// File: rtl/fifo_stream_reader.sv
// FIFO-to-stream reader: a 2-entry skid buffer turns FIFO read data into a valid/ready burst stream.
// Optional FIFO_STREAM_READER_STATS_EN adds a 32-bit beat_cnt output counting accepted beats.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  err
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                  r_occ;
  occ_t                  w_occ_nxt;
  logic                  r_inflight;
  logic                  r_rst_d;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]      r_beat;

  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_orphan;
  logic                  w_overflow;
  logic                  w_rd_en;
  logic [2:0]            w_level;

  // Reads are issued only while the buffer plus the in-flight word has room after this cycle's pop.
  assign w_pop      = (r_occ != EMPTY) && m_ready;
  assign w_level    = 3'(r_occ) + 3'(r_inflight);
  assign w_rd_en    = !rst && !r_rst_d && !fifo_empty && (w_level < (3'd2 + 3'(w_pop)));

  // Data returning in the first cycle after reset belongs to a discarded read.
  assign w_push_req = fifo_valid && !r_rst_d;
  assign w_orphan   = w_push_req && !r_inflight;
  assign w_overflow = w_push_req && r_inflight && (r_occ == FULL) && !w_pop;
  assign w_push     = w_push_req && r_inflight && !w_overflow;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) r_occ <= EMPTY;
    else     r_occ <= w_occ_nxt;
  end

  // Occupancy next-state.
  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_nxt = (r_occ == EMPTY) ? HALF : FULL;
      2'b01:   w_occ_nxt = (r_occ == FULL) ? HALF : EMPTY;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Skid buffer storage, read tracking, error flag and burst position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
      r_rst_d    <= 1'b1;
      r_err      <= 1'b0;
      r_beat     <= '0;
    end else begin
      r_rst_d    <= 1'b0;
      r_inflight <= w_rd_en;
      if (w_orphan || w_overflow) r_err <= 1'b1;
      if (w_pop) r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + CNT_W'(1);
      if (w_pop) begin
        if (r_occ == FULL) begin
          r_head <= r_tail;
          if (w_push) r_tail <= fifo_dout;
        end else if (w_push) begin
          r_head <= fifo_dout;
        end
      end else if (w_push) begin
        if (r_occ == EMPTY) r_head <= fifo_dout;
        else                r_tail <= fifo_dout;
      end
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (r_occ != EMPTY);
  assign m_data     = r_head;
  assign m_last     = m_valid && (r_beat == LAST_BEAT);
  assign err        = r_err;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] r_beat_cnt;

  always_ff @(posedge clk) begin
    if (rst)        r_beat_cnt <= '0;
    else if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO, expected-word queue and burst position model.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 16;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_valid;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          err;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]   beat_cnt;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .err        (err)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec;
  int            n_err;
  int            n_beats;
  int            cyc;
  int            first_cyc;
  int            last_cyc;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          inj_valid;
  logic [DW-1:0] inj_data;
  logic          toggle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample DUT before the edge, then update the FIFO model after it.
  task automatic tick();
    logic rd;
    logic [DW-1:0] w;
    #1;
    rd = fifo_rd_en;
    if (rd) chk("rd_while_empty", 32'(fifo_empty), 32'd0);
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("data", 32'(m_data), 32'(w));
      end
      chk("last", 32'(m_last), 32'((n_beats % BL) == (BL - 1)));
      n_beats++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    @(posedge clk);
    #1;
    fifo_valid = rd || inj_valid;
    if (inj_valid) fifo_dout = inj_data;
    else if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    inj_valid  = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    if (toggle) m_ready = ~m_ready;
    cyc++;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + DW'(i));
      exp_q.push_back(base + DW'(i));
    end
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    inj_valid = 1'b0;
    toggle = 1'b0;
    fifo_empty = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_beats = 0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < max_cyc) begin
      tick();
      i++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 3; k++) tick();
  endtask

  initial begin
    int lat;
    n_vec = 0; n_err = 0; n_beats = 0; cyc = 0;
    first_cyc = -1; last_cyc = -1;
    rst = 1'b1; fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = '0;
    m_ready = 1'b0; inj_valid = 1'b0; inj_data = '0; toggle = 1'b0;

    // Reset values
    do_reset();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    tick();

    // Streaming 0x01..0x20 with sink always ready
    m_ready = 1'b1;
    load(8'h01, 32);
    lat = 0;
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    first_cyc = -1;
    drain("stream_drain", 80);
    chk("stream_beats", 32'(n_beats), 32'd32);
    chk("no_bubbles", 32'(last_cyc - first_cyc + 1), 32'd32);

    // Backpressure: 8 words, sink stalled 10 cycles
    m_ready = 1'b0;
    load(8'h40, 8);
    for (int i = 0; i < 10; i++) tick();
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("bp_m_data", 32'(m_data), 32'h40);
    chk("bp_fifo_left", 32'(fifo_q.size()), 32'd6);
    m_ready = 1'b1;
    drain("bp_drain", 40);

    // Alternating ready over 16 words
    m_ready = 1'b1;
    toggle = 1'b1;
    load(8'h60, 16);
    drain("alt_drain", 80);
    toggle = 1'b0;
    chk("alt_beats", 32'(n_beats), 32'd56);

    // Mid-burst reset after beat 5, stale read data right after release
    do_reset();
    m_ready = 1'b1;
    load(8'h80, 16);
    for (int i = 0; i < 40 && n_beats < 5; i++) tick();
    chk("mid_beats", 32'(n_beats), 32'd5);
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    inj_valid = 1'b1;
    inj_data = 8'hEE;
    tick();
    rst = 1'b0;
    n_beats = 0;
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_m_last", 32'(m_last), 32'd0);
    tick();
    chk("stale_err", 32'(err), 32'd0);
    chk("stale_m_valid", 32'(m_valid), 32'd0);
    load(8'hA0, 16);
    drain("restart_drain", 60);
    chk("restart_beats", 32'(n_beats), 32'd16);

    // Error injection with one word held in the buffer
    do_reset();
    m_ready = 1'b0;
    load(8'hC3, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("ei_pre_err", 32'(err), 32'd0);
    inj_valid = 1'b1;
    inj_data = 8'h5A;
    tick();
    tick();
    chk("ei_err", 32'(err), 32'd1);
    chk("ei_m_data", 32'(m_data), 32'hC3);
    m_ready = 1'b1;
    drain("ei_drain", 10);
    chk("ei_empty_after", 32'(m_valid), 32'd0);
    chk("ei_err_held", 32'(err), 32'd1);
    do_reset();
    chk("ei_err_cleared", 32'(err), 32'd0);

`ifdef FIFO_STREAM_READER_STATS_EN
    // Accepted-beat statistics
    m_ready = 1'b1;
    load(8'h10, 40);
    drain("stats_drain", 100);
    chk("beat_cnt_40", beat_cnt, 32'd40);
    do_reset();
    chk("beat_cnt_rst", beat_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
